// File: rtl/module_pool_lanes_pkg.sv
// Shared encodings and default sizes for the 2x2 lane pooling pipeline.
package module_pool_lanes_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_LANES = 4;

endpackage

// File: rtl/module_pool_lanes_alu.sv
// Per-lane 2x2 pooling arithmetic: pairwise reduce (stage 1) and final reduce (stage 2).
// Purely combinational; the pipeline registers live in the top.
module pool_lane_alu
  import module_pool_lanes_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  pool_mode_e         s1_mode,
  input  logic [4*WIDTH-1:0] win,
  output logic [WIDTH:0]     pair_a,
  output logic [WIDTH:0]     pair_b,
  input  pool_mode_e         s2_mode,
  input  logic [WIDTH:0]     s2_pair_a,
  input  logic [WIDTH:0]     s2_pair_b,
  output logic [WIDTH-1:0]   result
);

  localparam int PW = WIDTH + 1;
  localparam int EW = WIDTH + 2;
  localparam logic [EW-1:0] ROUND = EW'(2'b10);

  // Everything is widened into a signed domain two bits wider than an element,
  // so one signed compare serves both the signed and unsigned configurations.
  function automatic logic [EW-1:0] ext_elem(input logic [WIDTH-1:0] v);
    return SIGNED ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
  endfunction

  function automatic logic [EW-1:0] ext_pair(input logic [PW-1:0] v);
    return SIGNED ? {v[PW-1], v} : {1'b0, v};
  endfunction

  function automatic logic [EW-1:0] max_ext(input logic [EW-1:0] x, input logic [EW-1:0] y);
    return ($signed(x) > $signed(y)) ? x : y;
  endfunction

  logic [EW-1:0]        w11, w12, w21, w22;
  logic signed [EW-1:0] quad_sum;
  logic signed [EW-1:0] avg_ext;
  logic [EW-1:0]        max_fin;

  always_comb begin
    w11 = ext_elem(win[0*WIDTH +: WIDTH]);
    w12 = ext_elem(win[1*WIDTH +: WIDTH]);
    w21 = ext_elem(win[2*WIDTH +: WIDTH]);
    w22 = ext_elem(win[3*WIDTH +: WIDTH]);
    if (s1_mode == POOL_AVG) begin
      pair_a = PW'(w11 + w12);
      pair_b = PW'(w21 + w22);
    end else begin
      pair_a = PW'(max_ext(w11, w12));
      pair_b = PW'(max_ext(w21, w22));
    end
  end

  always_comb begin
    quad_sum = $signed(ext_pair(s2_pair_a) + ext_pair(s2_pair_b) + ROUND);
    if (SIGNED) begin
      avg_ext = quad_sum >>> 2'd2;
    end else begin
      avg_ext = quad_sum >> 2'd2;
    end
    max_fin = max_ext(ext_pair(s2_pair_a), ext_pair(s2_pair_b));
    if (s2_mode == POOL_AVG) begin
      result = WIDTH'(avg_ext);
    end else begin
      result = WIDTH'(max_fin);
    end
  end

endmodule

// File: rtl/module_pool_lanes.sv
// Two-stage valid/ready pipeline pooling LANES 2x2 windows per beat (max or rounded average).
module module_pool_lanes
  import module_pool_lanes_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int LANES  = DEFAULT_LANES,
  parameter bit SIGNED = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [LANES*4*WIDTH-1:0] s_win,
  input  logic                     s_mode,
  input  logic                     s_zero_out,
  input  logic                     s_last,
  input  logic [WIDTH-1:0]         zero_point,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [LANES*WIDTH-1:0]   m_data,
  output logic                     m_last
);

  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic s_accept, s2_load;

  logic [LANES-1:0][WIDTH:0] pair_a_s, pair_b_s;
  logic [LANES-1:0][WIDTH:0] pair_a_d, pair_a_q, pair_b_d, pair_b_q;
  pool_mode_e                mode_d, mode_q;
  logic                      zero_out_d, zero_out_q;
  logic                      last_d, last_q;
  logic [WIDTH-1:0]          zp_d, zp_q;
  logic [LANES*WIDTH-1:0]    lane_res_s;
  logic [LANES*WIDTH-1:0]    m_data_d, m_data_q;
  logic                      m_last_d, m_last_q;

  assign s2_load  = s1_valid_q && (!s2_valid_q || m_ready);
  assign s_ready  = !s1_valid_q || !s2_valid_q || m_ready;
  assign s_accept = s_valid && s_ready;

  assign m_valid = s2_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pool_lane_alu #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
    ) u_alu (
      .s1_mode   (pool_mode_e'(s_mode)),
      .win       (s_win[l*4*WIDTH +: 4*WIDTH]),
      .pair_a    (pair_a_s[l]),
      .pair_b    (pair_b_s[l]),
      .s2_mode   (mode_q),
      .s2_pair_a (pair_a_q[l]),
      .s2_pair_b (pair_b_q[l]),
      .result    (lane_res_s[l*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    if (s_accept) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (m_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  always_comb begin
    if (s_accept) begin
      pair_a_d   = pair_a_s;
      pair_b_d   = pair_b_s;
      mode_d     = pool_mode_e'(s_mode);
      zero_out_d = s_zero_out;
      last_d     = s_last;
      zp_d       = zero_point;
    end else begin
      pair_a_d   = pair_a_q;
      pair_b_d   = pair_b_q;
      mode_d     = mode_q;
      zero_out_d = zero_out_q;
      last_d     = last_q;
      zp_d       = zp_q;
    end
  end

  // Padding beats bypass the lane arithmetic and present zero_point on every lane.
  always_comb begin
    if (s2_load) begin
      if (zero_out_q) begin
        m_data_d = {LANES{zp_q}};
      end else begin
        m_data_d = lane_res_s;
      end
      m_last_d = last_q;
    end else begin
      m_data_d = m_data_q;
      m_last_d = m_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
    end
  end

  always_ff @(posedge clk) begin
    pair_a_q   <= pair_a_d;
    pair_b_q   <= pair_b_d;
    mode_q     <= mode_d;
    zero_out_q <= zero_out_d;
    last_q     <= last_d;
    zp_q       <= zp_d;
  end

endmodule

// File: tb/tb_module_pool_lanes.sv
// Bench for module_pool_lanes: instance 0 unsigned, instance 1 signed, both WIDTH=8, LANES=4.
module tb_module_pool_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   s_valid, s_ready, s_mode, s_zero_out, s_last;
  logic [1:0]   m_valid, m_ready, m_last;
  logic [127:0] s_win [2];
  logic [7:0]   zp [2];
  logic [31:0]  m_data [2];

  int n_checks = 0;
  int n_errors = 0;
  bit rnd_ready = 1'b0;

  module_pool_lanes #(.WIDTH(8), .LANES(4), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_win(s_win[0]), .s_mode(s_mode[0]), .s_zero_out(s_zero_out[0]), .s_last(s_last[0]),
    .zero_point(zp[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_data(m_data[0]), .m_last(m_last[0])
  );

  module_pool_lanes #(.WIDTH(8), .LANES(4), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_win(s_win[1]), .s_mode(s_mode[1]), .s_zero_out(s_zero_out[1]), .s_last(s_last[1]),
    .zero_point(zp[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_data(m_data[1]), .m_last(m_last[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: pool each lane directly from the four window values as integers.
  function automatic logic [31:0] model(input logic [127:0] w, input logic mode,
                                        input logic zo, input logic [7:0] zpv, input bit sgn);
    logic [31:0] r;
    logic [7:0]  b;
    int          v [4];
    int          res;
    r = 32'd0;
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 4; k++) begin
        b = w[l*32 + k*8 +: 8];
        v[k] = sgn ? int'($signed(b)) : int'(b);
      end
      if (zo) begin
        res = int'(zpv);
      end else if (mode) begin
        res = (v[0] + v[1] + v[2] + v[3] + 2) >>> 2;
      end else begin
        res = v[0];
        for (int k = 1; k < 4; k++) if (v[k] > res) res = v[k];
      end
      r[l*8 +: 8] = res[7:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] pk(input logic [7:0] w11, input logic [7:0] w12,
                                     input logic [7:0] w21, input logic [7:0] w22);
    return {w22, w21, w12, w11};
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          acc;
  } exp_t;

  for (genvar d = 0; d < 2; d++) begin : g_mon
    exp_t        q [$];
    int          cyc = 0;
    int          last_stall = -1;
    int          n_out = 0;
    int          n_last = 0;
    bit          rst_seen = 1'b0;
    bit          hold_v = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;

    always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
        if (rst_seen) begin
          chk("reset_mvalid", 64'(m_valid[d]), 64'd0);
          chk("reset_mdata", 64'(m_data[d]), 64'd0);
          chk("reset_mlast", 64'(m_last[d]), 64'd0);
        end
        q.delete();
        hold_v   = 1'b0;
        rst_seen = 1'b1;
      end else begin
        if (rst_seen) begin
          chk("post_reset_mvalid", 64'(m_valid[d]), 64'd0);
          chk("post_reset_sready", 64'(s_ready[d]), 64'd1);
          rst_seen = 1'b0;
        end
        if (hold_v) begin
          chk("stall_valid", 64'(m_valid[d]), 64'd1);
          chk("stall_data", 64'(m_data[d]), 64'(hold_d));
          chk("stall_last", 64'(m_last[d]), 64'(hold_l));
        end
        if (!m_ready[d]) last_stall = cyc;
        if (m_valid[d] && m_ready[d]) begin
          if (q.size() == 0) begin
            fail("unexpected_output_beat");
          end else begin
            e = q.pop_front();
            chk("out_data", 64'(m_data[d]), 64'(e.data));
            chk("out_last", 64'(m_last[d]), 64'(e.last));
            n_out++;
            if (e.last) n_last++;
            if (last_stall < e.acc) chk("latency", 64'(cyc - e.acc), 64'd2);
          end
        end
        if (s_valid[d] && s_ready[d]) begin
          e.data = model(s_win[d], s_mode[d], s_zero_out[d], zp[d], d != 0);
          e.last = s_last[d];
          e.acc  = cyc;
          q.push_back(e);
          chk("in_flight_le2", 64'(q.size() <= 2), 64'd1);
        end
        hold_v = m_valid[d] && !m_ready[d];
        hold_d = m_data[d];
        hold_l = m_last[d];
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rnd_ready) m_ready[0] = 1'($urandom_range(0, 1));
  end

  task automatic send(input int d, input logic [127:0] w, input logic mode, input logic zo,
                      input logic last, input logic [7:0] zpv, output int waited);
    bit acc;
    s_valid[d] = 1'b1;
    s_win[d] = w;
    s_mode[d] = mode;
    s_zero_out[d] = zo;
    s_last[d] = last;
    zp[d] = zpv;
    waited = 0;
    forever begin
      @(negedge clk);
      acc = s_ready[d];
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 200) begin
        fail("send_timeout");
        break;
      end
    end
    s_valid[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  logic [127:0] filler;
  int           waited, n0, l0;

  initial begin
    rst_n = 1'b0;
    s_valid = 2'b00; s_mode = 2'b00; s_zero_out = 2'b00; s_last = 2'b00;
    m_ready = 2'b11;
    s_win[0] = 128'd0; s_win[1] = 128'd0; zp[0] = 8'd0; zp[1] = 8'd0;
    filler = {pk(8'd50, 8'd7, 8'd99, 8'd1), pk(8'd128, 8'd127, 8'd0, 8'd255), pk(8'd4, 8'd4, 8'd4, 8'd5), 32'd0};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("init_mvalid", 64'(m_valid[d]), 64'd0);
      chk("init_mdata", 64'(m_data[d]), 64'd0);
      chk("init_mlast", 64'(m_last[d]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("init_sready", 64'(s_ready), 64'd3);

    send(0, {filler[127:32], pk(8'd3, 8'd200, 8'd17, 8'd9)}, 1'b0, 1'b0, 1'b0, 8'd0, waited);
    @(posedge clk); #1;
    chk("max_valid_at_2", 64'(m_valid[0]), 64'd1);
    chk("max_lane0", 64'(m_data[0][7:0]), 64'd200);

    send(0, {filler[127:32], pk(8'd1, 8'd2, 8'd3, 8'd4)}, 1'b1, 1'b0, 1'b0, 8'd0, waited);
    @(posedge clk); #1;
    chk("avg_lane0_small", 64'(m_data[0][7:0]), 64'd3);

    send(0, {filler[127:32], pk(8'd255, 8'd255, 8'd255, 8'd254)}, 1'b1, 1'b0, 1'b0, 8'd0, waited);
    @(posedge clk); #1;
    chk("avg_lane0_top", 64'(m_data[0][7:0]), 64'd255);

    send(0, {filler[127:32], pk(8'd9, 8'd9, 8'd9, 8'd9)}, 1'b1, 1'b1, 1'b0, 8'h80, waited);
    @(posedge clk); #1;
    chk("zero_out_all_lanes", 64'(m_data[0]), 64'h8080_8080);
    send(0, {filler[127:32], pk(8'd10, 8'd20, 8'd30, 8'd5)}, 1'b0, 1'b0, 1'b0, 8'h80, waited);
    @(posedge clk); #1;
    chk("after_zero_out", 64'(m_data[0][7:0]), 64'd30);

    send(1, {filler[127:32], pk(8'hFB, 8'hFF, 8'h80, 8'hF9)}, 1'b0, 1'b0, 1'b0, 8'd0, waited);
    @(posedge clk); #1;
    chk("signed_max", 64'(m_data[1][7:0]), 64'hFF);
    send(1, {filler[127:32], pk(8'hFF, 8'hFE, 8'hFE, 8'hFE)}, 1'b1, 1'b0, 1'b0, 8'd0, waited);
    @(posedge clk); #1;
    chk("signed_avg", 64'(m_data[1][7:0]), 64'hFE);

    for (int i = 0; i < 6; i++) begin
      send(i % 2, {$urandom, $urandom, $urandom, $urandom}, 1'(i % 3 == 0), 1'b0, 1'b0, 8'd0, waited);
      chk("no_bubble_accept", 64'(waited), 64'd0);
    end
    repeat (4) @(posedge clk);
    #1;

    n0 = g_mon[0].n_out;
    l0 = g_mon[0].n_last;
    rnd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(0, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'(i == 7 || i == 15), 8'($urandom), waited);
    end
    rnd_ready = 1'b0;
    m_ready[0] = 1'b1;
    for (int t = 0; t < 50 && g_mon[0].q.size() != 0; t++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("stream_drained", 64'(g_mon[0].q.size()), 64'd0);
    chk("stream_count", 64'(g_mon[0].n_out - n0), 64'd16);
    chk("stream_lasts", 64'(g_mon[0].n_last - l0), 64'd2);

    m_ready[0] = 1'b0;
    send(0, {filler[127:32], pk(8'd1, 8'd1, 8'd1, 8'd1)}, 1'b0, 1'b0, 1'b1, 8'd0, waited);
    send(0, {filler[127:32], pk(8'd2, 8'd2, 8'd2, 8'd2)}, 1'b0, 1'b0, 1'b1, 8'd0, waited);
    chk("two_in_flight_mvalid", 64'(m_valid[0]), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_drops_mvalid", 64'(m_valid[0]), 64'd0);
    rst_n = 1'b1;
    m_ready[0] = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_stale_beat", 64'(m_valid[0]), 64'd0);
      chk("ready_after_reset", 64'(s_ready[0]), 64'd1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/module_pool_lanes.md
MODULE_POOL_LANES -- requirements
Module: module_pool_lanes

Interface
REQ-001 SHALL have parameter WIDTH, default 8, element bit width.
REQ-002 SHALL have parameter LANES, default 4, channels pooled in parallel per beat.
REQ-003 SHALL have parameter SIGNED, default 0; 1 means elements and zero_point are two's complement.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port s_valid  input  1  input beat valid.
REQ-007 SHALL have port s_ready  output  1  input beat accepted when s_valid&s_ready.
REQ-008 SHALL have port s_win  input  LANES*4*WIDTH  per lane L, bits [L*4*WIDTH +: 4*WIDTH] hold w11,w12,w21,w22 from LSB up.
REQ-009 SHALL have port s_mode  input  1  0 = max pool, 1 = average pool.
REQ-010 SHALL have port s_zero_out  input  1  beat is padding; all lanes output zero_point.
REQ-011 SHALL have port s_last  input  1  last beat of a row, carried to m_last.
REQ-012 SHALL have port zero_point  input  WIDTH  quantisation zero value, sampled with the beat.
REQ-013 SHALL have port m_valid  output  1  output beat valid.
REQ-014 SHALL have port m_ready  input  1  downstream accepts when m_valid&m_ready.
REQ-015 SHALL have port m_data  output  LANES*WIDTH  lane L result in [L*WIDTH +: WIDTH].
REQ-016 SHALL have port m_last  output  1  s_last of the beat shown on m_data.

Function
REQ-017 SHALL be a 2-stage pipeline (S1, S2), each stage with its own valid bit; S2 registers drive m_*.
REQ-018 S1 SHALL register per lane max(w11,w12), max(w21,w22) in max mode, or sums w11+w12, w21+w22 (WIDTH+1 bits) in average mode, plus mode, zero_out, last, zero_point.
REQ-019 S2 SHALL register the final max, or (pairsum_a+pairsum_b+2)>>2 (WIDTH+2-bit sum, arithmetic shift when SIGNED=1), truncated to WIDTH.
REQ-020 Comparisons and sums SHALL be signed when SIGNED=1, unsigned otherwise.
REQ-021 When a beat has zero_out=1, S2 SHALL output zero_point on every lane regardless of mode or window data.
REQ-022 Latency SHALL be exactly 2 cycles from acceptance to m_valid when m_ready stays 1.
REQ-023 S2 SHALL load when S1 is valid and (!m_valid || m_ready); S1 SHALL load when s_valid && s_ready.
REQ-024 s_ready SHALL equal !S1_valid || !m_valid || m_ready (combinational, no dependence on s_valid).
REQ-025 Sustained throughput SHALL be one beat per cycle while m_ready=1.
REQ-026 While m_valid=1 and m_ready=0, m_data, m_last and m_valid SHALL hold stable.
REQ-027 Accepted beats SHALL never be dropped, duplicated or reordered; at most 2 beats in flight.
REQ-028 Simultaneous accept on input and output in one cycle SHALL be supported with no bubble.
REQ-029 mode, zero_out, zero_point SHALL be per beat; changing them between beats affects only later beats.

Reset
REQ-030 While rst_n=0 at a clock edge, S1_valid, S2_valid, m_valid, m_last SHALL clear to 0 and m_data to 0.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; s_ready SHALL be 1 the cycle after reset releases.
REQ-032 Datapath registers other than m_data need no reset.

Structure
REQ-033 A shared package SHALL hold the mode encodings (POOL_MAX=0, POOL_AVG=1) and default WIDTH/LANES constants.
REQ-034 The per-lane pairwise/final max-or-average arithmetic SHALL be a sub-module pool_lane_alu (parameters WIDTH, SIGNED), instantiated LANES times via generate; valid/ready control stays in the top.

Verification
REQ-035 Max, WIDTH=8, LANES=4, unsigned, lane0 window {3,200,17,9}, m_ready=1 -> lane0 = 200 exactly 2 cycles after accept.
REQ-036 Average, unsigned, window {1,2,3,4} -> 3 ((10+2)>>2); window {255,255,255,254} -> 255.
REQ-037 SIGNED=1, max of {-5,-1,-128,-7} -> -1; average of {-1,-2,-2,-2} -> -2 (floor((-7+2)/4)).
REQ-038 zero_out=1, zero_point=0x80, any window -> all lanes 0x80; next beat zero_out=0 pools normally.
REQ-039 Stream of 16 beats with random m_ready backpressure -> 16 outputs in order, m_data stable while stalled, m_last on beats 8 and 16 only.
REQ-040 rst_n=0 asserted with 2 beats in flight -> m_valid=0 next cycle, no stale beat emerges after release.
